// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types for the register-file writeback scheduler
package regfile_pkg;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - 2-entry FIFO buffering LSU writeback returns
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module wb_skid_fifo
  import regfile_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_valid,
  output logic    push_ready,
  input  wb_req_t push_data,
  output logic    pop_valid,
  input  logic    pop_ready,
  output wb_req_t pop_data
);
  wb_req_t    mem0, mem1;
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       push_fire, pop_fire;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = rd_ptr ? mem1 : mem0;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_fire) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop_fire) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_fire} - {1'b0, pop_fire};
    end
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - ALU/LSU writeback arbiter and long-latency scoreboard
// Optional REGFILE_WB_BYPASS_EN: releases hazards on the register being written back this cycle.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      issue_valid_i,
  input  reg_addr_t issue_rs1_i,
  input  reg_addr_t issue_rs2_i,
  input  reg_addr_t issue_rd_i,
  input  logic      issue_long_i,
  output logic      issue_stall_o,
  input  logic      alu_we_i,
  input  reg_addr_t alu_rd_i,
  input  xlen_t     alu_data_i,
  input  logic      lsu_valid_i,
  output logic      lsu_ready_o,
  input  reg_addr_t lsu_rd_i,
  input  xlen_t     lsu_data_i,
  output reg_addr_t rd_addr,
  output xlen_t     rd_data,
  output logic      rd_wren
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output xlen_t     bypass_data_o,
  output logic      bypass_hit_rs1_o,
  output logic      bypass_hit_rs2_o
`endif
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [NUM_REGS-1:0] pending, pend_eff;
  logic [CW-1:0]       out_cnt;
  logic [7:0]          starve_cnt;
  logic                clr_valid;
  reg_addr_t           clr_rd;
  wb_req_t             fifo_head, lsu_req;
  logic                fifo_valid, pop;
  logic                hazard, out_full, starved, issue_fire, long_fire;

  assign lsu_req.rd   = lsu_rd_i;
  assign lsu_req.data = lsu_data_i;

  wb_skid_fifo u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_valid (lsu_valid_i),
    .push_ready (lsu_ready_o),
    .push_data  (lsu_req),
    .pop_valid  (fifo_valid),
    .pop_ready  (!alu_we_i),
    .pop_data   (fifo_head)
  );

  assign pop = fifo_valid && !alu_we_i;

  // clr_* marks an LSU entry sitting on the write port; its pending bit drops at the end of that cycle
  always_comb begin
    pend_eff = pending;
`ifdef REGFILE_WB_BYPASS_EN
    if (clr_valid) pend_eff[clr_rd] = 1'b0;
`endif
    hazard   = pend_eff[issue_rs1_i] || pend_eff[issue_rs2_i] ||
               ((issue_rd_i != 5'd0) && pend_eff[issue_rd_i]);
    out_full = issue_long_i && (out_cnt == CW'(MAX_OUT));
    starved  = (starve_cnt >= 8'(STARVE_LIMIT));
    issue_stall_o = issue_valid_i && (hazard || out_full || starved);
  end

  assign issue_fire = issue_valid_i && !issue_stall_o;
  assign long_fire  = issue_fire && issue_long_i;

`ifdef REGFILE_WB_BYPASS_EN
  assign bypass_data_o    = rd_data;
  assign bypass_hit_rs1_o = clr_valid && (clr_rd == issue_rs1_i) && (issue_rs1_i != 5'd0);
  assign bypass_hit_rs2_o = clr_valid && (clr_rd == issue_rs2_i) && (issue_rs2_i != 5'd0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending    <= '0;
      out_cnt    <= '0;
      starve_cnt <= '0;
      clr_valid  <= 1'b0;
      clr_rd     <= '0;
    end else begin
      // a new long issue to the register being cleared must win
      if (clr_valid) pending[clr_rd] <= 1'b0;
      if (long_fire && (issue_rd_i != 5'd0)) pending[issue_rd_i] <= 1'b1;

      if (long_fire && !pop)                         out_cnt <= out_cnt + CW'(1);
      else if (!long_fire && pop && (out_cnt != '0)) out_cnt <= out_cnt - CW'(1);

      if (fifo_valid && alu_we_i) begin
        if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= '0;
      end

      clr_valid <= pop;
      clr_rd    <= fifo_head.rd;
    end
  end

  // x0 writes are granted but never enabled: the register file does not clear x0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_wren <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      rd_wren <= (alu_we_i && (alu_rd_i != 5'd0)) || (pop && (fifo_head.rd != 5'd0));
      if (alu_we_i) begin
        rd_addr <= alu_rd_i;
        rd_data <= alu_data_i;
      end else if (pop) begin
        rd_addr <= fifo_head.rd;
        rd_data <= fifo_head.data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - randomized and directed bench for regfile_wb_sched
`timescale 1ns/1ps
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  localparam int MAX_OUT      = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0, issue_long_i = 1'b0;
  logic [4:0]  issue_rs1_i = '0, issue_rs2_i = '0, issue_rd_i = '0;
  logic        issue_stall_o;
  logic        alu_we_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        lsu_valid_i = 1'b0;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i = '0;
  logic [31:0] lsu_data_i = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
`ifdef REGFILE_WB_BYPASS_EN
  logic [31:0] bypass_data_o;
  logic        bypass_hit_rs1_o, bypass_hit_rs2_o;
`endif

  always #5 clk_i = ~clk_i;

  regfile_wb_sched #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_valid_i (issue_valid_i),
    .issue_rs1_i   (issue_rs1_i),
    .issue_rs2_i   (issue_rs2_i),
    .issue_rd_i    (issue_rd_i),
    .issue_long_i  (issue_long_i),
    .issue_stall_o (issue_stall_o),
    .alu_we_i      (alu_we_i),
    .alu_rd_i      (alu_rd_i),
    .alu_data_i    (alu_data_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_data_i    (lsu_data_i),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_wren       (rd_wren)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .bypass_data_o    (bypass_data_o),
    .bypass_hit_rs1_o (bypass_hit_rs1_o),
    .bypass_hit_rs2_o (bypass_hit_rs2_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural state of the scheduler
  bit [31:0]   m_pend;
  int          m_out, m_starve;
  wb_req_t     m_q[$];
  logic        m_wren, m_wb_lsu;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [4:0]  out_list[$];
  logic        obs_stall, obs_ready;

  task automatic model_reset();
    m_pend = '0; m_out = 0; m_starve = 0; m_q.delete();
    m_wren = 1'b0; m_wb_lsu = 1'b0; m_addr = '0; m_data = '0;
    out_list.delete();
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check write port
  task automatic step(input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input bit lng, input bit awe,
                      input logic [4:0] ard, input logic [31:0] adat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bit [31:0] eff;
    bit        exp_stall, exp_ready, acc, pop;
    wb_req_t   e;
    issue_valid_i = iv; issue_rs1_i = rs1; issue_rs2_i = rs2; issue_rd_i = rd;
    issue_long_i = lng; alu_we_i = awe; alu_rd_i = ard; alu_data_i = adat;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ldat;
    eff = m_pend;
`ifdef REGFILE_WB_BYPASS_EN
    if (m_wb_lsu) eff[m_addr] = 1'b0;
`endif
    exp_ready = (m_q.size() < 2);
    exp_stall = iv && (eff[rs1] || eff[rs2] || (rd != 0 && eff[rd]) ||
                       (lng && m_out == MAX_OUT) || (m_starve >= STARVE_LIMIT));
    #1;
    obs_stall = issue_stall_o;
    obs_ready = lsu_ready_o;
    check_eq("issue_stall", issue_stall_o, exp_stall);
    check_eq("lsu_ready", lsu_ready_o, exp_ready);
`ifdef REGFILE_WB_BYPASS_EN
    check_eq("bypass_hit_rs1", bypass_hit_rs1_o, m_wb_lsu && m_addr == rs1 && rs1 != 0);
    check_eq("bypass_hit_rs2", bypass_hit_rs2_o, m_wb_lsu && m_addr == rs2 && rs2 != 0);
    check_eq("bypass_data", bypass_data_o, m_data);
`endif
    acc = iv && !exp_stall;
    pop = !awe && (m_q.size() > 0);
    if (m_q.size() > 0 && awe) m_starve = (m_starve < 255) ? m_starve + 1 : 255;
    else                       m_starve = 0;
    if (m_wb_lsu) m_pend[m_addr] = 1'b0;
    if (acc && lng && rd != 0) m_pend[rd] = 1'b1;
    if (acc && lng) begin
      m_out++;
      out_list.push_back(rd);
    end
    if (pop && m_out > 0) m_out--;
    m_wb_lsu = pop;
    if (awe) begin
      m_wren = (ard != 0); m_addr = ard; m_data = adat;
    end else if (pop) begin
      e = m_q.pop_front();
      m_wren = (e.rd != 0); m_addr = e.rd; m_data = e.data;
    end else begin
      m_wren = 1'b0;
    end
    if (lv && exp_ready) begin
      e.rd = lrd; e.data = ldat;
      m_q.push_back(e);
      void'(out_list.pop_front());
    end
    @(posedge clk_i);
    #1;
    check_eq("rd_wren", rd_wren, m_wren);
    check_eq("rd_addr", rd_addr, m_addr);
    check_eq("rd_data", rd_data, m_data);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input bit lng);
    step(1, rs1, rs2, rd, lng, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_step();
    bit         lv;
    logic [4:0] lrd;
    lv  = (out_list.size() > 0) && ($urandom_range(0, 2) != 0);
    lrd = (out_list.size() > 0) ? out_list[0] : 5'd0;
    step($urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1),
         5'($urandom_range(0, 7)), $urandom, lv, lrd, $urandom);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (out_list.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 0, 1, out_list[0], $urandom);
      else                     idle();
      done = (out_list.size() == 0) && (m_q.size() == 0) && !m_wb_lsu && (m_pend == 0);
    end
    check_eq("drain_done", done, 1);
  endtask

  task automatic do_reset();
    issue_valid_i = 0; issue_long_i = 0; alu_we_i = 0; lsu_valid_i = 0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_async_wren", rd_wren, 0);
    check_eq("rst_async_addr", rd_addr, 0);
    check_eq("rst_async_data", rd_data, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("reset_wren", rd_wren, 0);
    check_eq("reset_addr", rd_addr, 0);
    check_eq("reset_data", rd_data, 0);
    check_eq("reset_ready", lsu_ready_o, 1);

    // ALU write at cycle 3 visible in cycle 4
    repeat (3) idle();
    step(0, 0, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0);
    check_eq("alu_x5_wren", rd_wren, 1);
    check_eq("alu_x5_addr", rd_addr, 5);
    check_eq("alu_x5_data", rd_data, 32'h1234);

    // RAW on a long-latency destination
    iss(1, 2, 7, 1);
    check_eq("long_x7_accept", obs_stall, 0);
    iss(7, 0, 3, 0);
    check_eq("raw_x7_stall", obs_stall, 1);
    step(1, 7, 0, 3, 0, 0, 0, 0, 1, 5'd7, 32'hCAFE_0007);
    check_eq("raw_x7_push", obs_stall, 1);
    iss(7, 0, 3, 0);
    check_eq("raw_x7_popdec", obs_stall, 1);
    iss(7, 0, 3, 0);
    check_eq("lsu_x7_wren", rd_wren, 0);
`ifdef REGFILE_WB_BYPASS_EN
    check_eq("raw_x7_bypass", obs_stall, 0);
`else
    check_eq("raw_x7_wb_cycle", obs_stall, 1);
`endif
    iss(7, 0, 3, 0);
    check_eq("raw_x7_release", obs_stall, 0);

    // starvation throttle
    iss(0, 0, 9, 1);
    step(0, 0, 0, 0, 0, 1, 5'd1, 32'h11, 1, 5'd9, 32'h99);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      step(1, 1, 2, 3, 0, 1, 5'd2, $urandom, 0, 0, 0);
      check_eq("starve_pre", obs_stall, 0);
    end
    step(1, 1, 2, 3, 0, 1, 5'd2, $urandom, 0, 0, 0);
    check_eq("starve_stall", obs_stall, 1);
    iss(1, 2, 3, 0);
    check_eq("starve_pop_cycle", obs_stall, 1);
    check_eq("starve_pop_data", rd_data, 32'h99);
    iss(1, 2, 3, 0);
    check_eq("starve_cleared", obs_stall, 0);

    // outstanding limit
    for (int i = 0; i < MAX_OUT; i++) begin
      iss(0, 0, 5'(10 + i), 1);
      check_eq("maxout_accept", obs_stall, 0);
    end
    iss(0, 0, 5'd14, 1);
    check_eq("maxout_stall", obs_stall, 1);
    iss(1, 2, 3, 0);
    check_eq("maxout_short_ok", obs_stall, 0);
    drain();

    // x0 never written
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    check_eq("x0_alu_wren", rd_wren, 0);
    for (int i = 0; i < MAX_OUT; i++) iss(0, 0, 0, 1);
    iss(0, 0, 0, 1);
    check_eq("x0_maxout_stall", obs_stall, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
    idle();
    check_eq("x0_lsu_wren", rd_wren, 0);
    iss(0, 0, 0, 1);
    check_eq("x0_out_dec", obs_stall, 0);
    drain();

    // reset with FIFO full and pending bits set
    iss(0, 0, 20, 1);
    iss(0, 0, 21, 1);
    step(0, 0, 0, 0, 0, 1, 5'd3, 32'h3, 1, 5'd20, 32'h20);
    step(0, 0, 0, 0, 0, 1, 5'd4, 32'h4, 1, 5'd21, 32'h21);
    check_eq("pre_rst_full", lsu_ready_o, 0);
    do_reset();
    iss(20, 21, 20, 1);
    check_eq("post_rst_stall", obs_stall, 0);
    check_eq("post_rst_ready", obs_ready, 1);
    drain();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) rand_step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Writeback scheduler and scoreboard for the single-write-port register file in the forwarding pipeline. It merges the fixed-latency ALU writeback stream and the variable-latency LSU return stream onto the one `rd_addr/rd_data/rd_wren` port. It tracks registers with outstanding long-latency writes and stalls decode on RAW/WAW hazards against them. It never writes x0, because the register file does not clear x0 on reset.

## Interface
Parameters:
- `MAX_OUT`, default 4: maximum outstanding long-latency (LSU) operations; range 1..15.
- `STARVE_LIMIT`, default 8: consecutive cycles a non-empty LSU buffer may lose arbitration before issue is throttled; range 1..255.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `issue_valid_i`  in  1  decode presents an instruction.
- `issue_rs1_i`, `issue_rs2_i`  in  5  source registers; x0 never hazards.
- `issue_rd_i`  in  5  destination register.
- `issue_long_i`  in  1  instruction writes back through the LSU.
- `issue_stall_o`  out  1  decode must hold; the instruction is not accepted.
- `alu_we_i`  in  1  ALU writeback valid; always accepted, no backpressure.
- `alu_rd_i`  in  5  ALU writeback register.
- `alu_data_i`  in  32  ALU writeback data.
- `lsu_valid_i`  in  1  LSU return valid.
- `lsu_ready_o`  out  1  LSU return accepted when high with valid.
- `lsu_rd_i`  in  5  LSU return register.
- `lsu_data_i`  in  32  LSU return data.
- `rd_addr`  out  5  register file write address.
- `rd_data`  out  32  register file write data.
- `rd_wren`  out  1  register file write enable.

## Operation
- LSU returns enter a 2-entry FIFO. `lsu_ready_o` = FIFO not full.
- Arbitration, once per cycle:
  - An ALU write (`alu_we_i`) always wins.
  - Otherwise a non-empty FIFO pops its head onto the write port.
  - Writes with rd = 0 are granted normally, but `rd_wren` is forced to 0.
- Scoreboard `pending[31:1]`:
  - Set bit rd on an accepted issue with `issue_long_i`=1 and rd≠0.
  - Clear bit rd when an LSU entry is popped.
- Outstanding counter `out_cnt`, 0..`MAX_OUT`:
  - +1 on accepted long issue, including rd=0.
  - −1 on LSU pop.
  - Both in the same cycle: unchanged.
- Starve counter:
  - +1 (saturating) each cycle the FIFO is non-empty and the ALU wins.
  - Cleared on any LSU pop or when the FIFO is empty.
- `issue_stall_o` = `issue_valid_i` AND any of:
  - `pending[rs1]`
  - `pending[rs2]`
  - `pending[rd]` with rd≠0 (WAW)
  - `issue_long_i` AND `out_cnt`==`MAX_OUT`
  - starve counter ≥ `STARVE_LIMIT`
- Hazard checks use the registered `pending` value; there is no same-cycle bypass unless configured (see Configuration).
- LSU returns for a register with no pending bit set are a protocol error. The block clears nothing extra and still writes the data.

## Timing
- Reset values: all outputs 0, `pending` 0, `out_cnt` 0, FIFO empty, starve counter 0. After reset `lsu_ready_o`=1 combinationally.
- Write port outputs are registered, giving 1-cycle latency:
  - An ALU input at cycle N appears on `rd_*` in cycle N+1.
  - The register file latches it at the end of N+1.
- An LSU pop decided in cycle N drives `rd_*` in N+1. Its pending bit clears at the same edge the register file latches (end of N+1). A dependent issue is released in N+2 and reads the new value combinationally.
- `issue_stall_o` and `lsu_ready_o` are combinational from inputs and state.
- LSU push and pop in the same cycle on a full FIFO: ready stays 0. A push into a full FIFO is not accepted.
- Reset mid-operation:
  - In-flight FIFO entries, pending bits and counters are discarded.
  - `rd_wren` drops immediately, asynchronously.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: a hazard on a register whose pending bit is being cleared this cycle (LSU entry on the write port) does not stall. The write-port data is also presented on `bypass_data_o` (32, out, reset 0) with `bypass_hit_rs1_o`/`bypass_hit_rs2_o` (1 each, reset 0) for the forwarding mux. Dependent issue is released in N+1.
- Not defined: those ports are absent. Stall behaviour is as in Operation.

## Structure
- Shared package `regfile_pkg`:
  - `reg_addr_t` (5-bit)
  - `xlen_t` (32-bit)
  - `NUM_REGS` = 32
  - `wb_req_t` struct {rd, data}
- Sub-module `wb_skid_fifo`: 2-entry FIFO of `wb_req_t` with valid/ready push and pop; it is the only natural split.
- Scoreboard, counters and arbiter live in the top module.

## Test plan
- ALU write x5=0x1234 at cycle 3 -> `rd_wren`=1, `rd_addr`=5, `rd_data`=0x1234 in cycle 4.
- Long issue rd=x7, then issue with rs1=x7 -> stall held until LSU return for x7 is popped, released 2 cycles after the pop decision (1 with `REGFILE_WB_BYPASS_EN`).
- ALU writes every cycle while LSU holds 1 entry -> after `STARVE_LIMIT`=8 losses `issue_stall_o`=1. The first ALU-idle cycle pops the LSU entry and the starve counter clears.
- `MAX_OUT`=4 long issues without returns -> the 5th long issue stalls. A non-long issue with no hazards is accepted.
- ALU write rd=x0 data 0xFFFF_FFFF, and LSU return rd=x0 -> `rd_wren` stays 0. The load still decrements `out_cnt`.
- Reset asserted with FIFO full and pending bits set -> outputs 0 at once, and after deassert `lsu_ready_o`=1 with no stalls.
